// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM states,
// branch condition codes and the next-PC target arithmetic.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   typedef enum logic [2:0] {
      PC_HOLD   = 3'd0,
      PC_SEQ    = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JUMP   = 3'd3,
      PC_JREG   = 3'd4
   } pc_sel_t;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BGTZ = 3'b010;
   localparam logic [2:0] BR_BGEZ = 3'b011;
   localparam logic [2:0] BR_BLTZ = 3'b100;
   localparam logic [2:0] BR_BLEZ = 3'b101;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Word offset is sign-extended and scaled; the add wraps modulo 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] pc_4,
                                                 input logic [15:0] imm);
      logic [31:0] offset;
      offset = {{14{imm[15]}}, imm, 2'b00};
      return pc_4 + offset;
   endfunction

   function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                               input logic [25:0] index);
      return {pc_hi, index, 2'b00};
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides whether the condition selected by
// the branch code holds for the register operands.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [2:0]  code,
   input  logic [31:0] bus_a,
   input  logic [31:0] bus_b,
   output logic        taken
);

   logic signed [31:0] a_signed;

   assign a_signed = $signed(bus_a);

   // Codes 110 and 111 are reserved and never taken.
   always_comb begin
      taken = 1'b0;
      case (code)
         BR_BEQ:  taken = (bus_a == bus_b);
         BR_BNE:  taken = (bus_a != bus_b);
         BR_BGTZ: taken = (a_signed > 32'sd0);
         BR_BGEZ: taken = (a_signed >= 32'sd0);
         BR_BLTZ: taken = (a_signed < 32'sd0);
         BR_BLEZ: taken = (a_signed <= 32'sd0);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch and next-PC stage: owns the PC, fetches over a req/ready
// handshake, holds the instruction for one execute cycle, then resolves the next PC.
module ifetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_4,
   input  logic        exec_stall,
   input  logic [3:0]  branch,
   input  logic        jump,
   input  logic        jreg,
   input  logic        pc_wr,
   input  logic [31:0] bus_a,
   input  logic [31:0] bus_b,
   output logic        halted,
   output logic        fault
);

   fetch_state_t state;
   fetch_state_t state_next;
   pc_sel_t      pc_sel;
   logic [31:0]  pc_next;
   logic [31:0]  instr_next;
   logic         fault_next;
   logic         br_taken;

   branch_cond u_branch_cond (
      .code  (branch[3:1]),
      .bus_a (bus_a),
      .bus_b (bus_b),
      .taken (br_taken)
   );

   assign pc_4        = pc + 32'd4;
   assign imem_addr   = pc;
   assign imem_req    = rst_n && (state == FETCH);
   assign instr_valid = (state == EXEC);
   assign halted      = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         pc    <= RESET_PC;
         instr <= 32'd0;
         fault <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         instr <= instr_next;
         fault <= fault_next;
      end
   end

   // A stalled execute cycle and every halt outcome keep the PC on the
   // current instruction, so a halt always reports where the core stopped.
   always_comb begin
      state_next = state;
      instr_next = instr;
      fault_next = fault;
      pc_sel     = PC_HOLD;
      case (state)
         FETCH: begin
            if (imem_ready) begin
               instr_next = imem_rdata;
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (!exec_stall) begin
               state_next = FETCH;
               if (!pc_wr) begin
                  state_next = HALT;
               end else if (jump && jreg) begin
                  if (bus_a[1:0] != 2'b00) begin
                     state_next = HALT;
                     fault_next = 1'b1;
                  end else begin
                     pc_sel = PC_JREG;
                  end
               end else if (jump) begin
                  pc_sel = PC_JUMP;
               end else if (branch[0] && br_taken) begin
                  pc_sel = PC_BRANCH;
               end else begin
                  pc_sel = PC_SEQ;
               end
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   always_comb begin
      pc_next = pc;
      case (pc_sel)
         PC_SEQ:    pc_next = pc_4;
         PC_BRANCH: pc_next = branch_target(pc_4, instr[15:0]);
         PC_JUMP:   pc_next = jump_target(pc_4[31:28], instr[25:0]);
         PC_JREG:   pc_next = bus_a;
         default:   pc_next = pc;
      endcase
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: drives fetch handshakes and decoded
// controls, comparing outputs against hand-computed values.
module tb_ifetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_4;
   logic        exec_stall;
   logic [3:0]  branch;
   logic        jump;
   logic        jreg;
   logic        pc_wr;
   logic [31:0] bus_a;
   logic [31:0] bus_b;
   logic        halted;
   logic        fault;

   int vectors;
   int miscompares;

   ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_4        (pc_4),
      .exec_stall  (exec_stall),
      .branch      (branch),
      .jump        (jump),
      .jreg        (jreg),
      .pc_wr       (pc_wr),
      .bus_a       (bus_a),
      .bus_b       (bus_b),
      .halted      (halted),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full instruction: zero-wait fetch, then one execute cycle with the given controls.
   task automatic applyStimulus(input logic [31:0] word, input logic [3:0] br,
                                input logic jmp, input logic jr, input logic wr,
                                input logic [31:0] a, input logic [31:0] b);
      imem_ready = 1'b1;
      imem_rdata = word;
      tick();
      imem_ready = 1'b0;
      branch = br; jump = jmp; jreg = jr; pc_wr = wr; bus_a = a; bus_b = b;
      checkOutput("exec_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("exec_instr", instr, word);
      tick();
      branch = 4'd0; jump = 1'b0; jreg = 1'b0; pc_wr = 1'b1; bus_a = 32'd0; bus_b = 32'd0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      imem_ready = 1'b0; imem_rdata = 32'd0; exec_stall = 1'b0;
      branch = 4'd0; jump = 1'b0; jreg = 1'b0; pc_wr = 1'b1;
      bus_a = 32'd0; bus_b = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_pc", pc, 32'h3000);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_halted", {31'd0, halted}, 32'd0);
      checkOutput("rst_fault", {31'd0, fault}, 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_req", {31'd0, imem_req}, 32'd1);
      checkOutput("rel_addr", imem_addr, 32'h3000);

      $display("[TB] zero-wait fetch");
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("zw_fetch_valid", {31'd0, instr_valid}, 32'd0);
         checkOutput("zw_fetch_addr", imem_addr, 32'h3000 + 32'(4 * i));
         tick();
         checkOutput("zw_exec_valid", {31'd0, instr_valid}, 32'd1);
         checkOutput("zw_exec_req", {31'd0, imem_req}, 32'd0);
         checkOutput("zw_exec_pc", pc, 32'h3000 + 32'(4 * i));
         checkOutput("zw_exec_pc4", pc_4, 32'h3004 + 32'(4 * i));
         tick();
      end
      imem_ready = 1'b0;

      $display("[TB] wait states and stall");
      imem_rdata = 32'h1234_5678;
      for (int k = 0; k < 3; k++) begin
         checkOutput("ws_addr", imem_addr, 32'h300C);
         checkOutput("ws_req", {31'd0, imem_req}, 32'd1);
         tick();
      end
      imem_ready = 1'b1;
      checkOutput("ws_addr_last", imem_addr, 32'h300C);
      tick();
      imem_ready = 1'b0;
      exec_stall = 1'b1;
      checkOutput("ws_instr", instr, 32'h1234_5678);
      checkOutput("ws_valid", {31'd0, instr_valid}, 32'd1);
      tick();
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("stall_pc", pc, 32'h300C);
      tick();
      exec_stall = 1'b0;
      checkOutput("stall_pc2", pc, 32'h300C);
      tick();
      checkOutput("post_stall_pc", pc, 32'h3010);
      checkOutput("post_stall_valid", {31'd0, instr_valid}, 32'd0);

      $display("[TB] branches and jumps");
      applyStimulus(32'h1085_FFFC, 4'b0001, 1'b0, 1'b0, 1'b1, 32'd5, 32'd5);
      checkOutput("beq_taken", pc, 32'h3004);
      applyStimulus(32'h0080_0008, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h3010, 32'd0);
      checkOutput("jr_3010", pc, 32'h3010);
      applyStimulus(32'h0480_FFFC, 4'b1001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd0);
      checkOutput("bltz_taken", pc, 32'h3004);
      applyStimulus(32'h0080_0008, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h3010, 32'd0);
      checkOutput("jr_3010b", pc, 32'h3010);
      applyStimulus(32'h1C80_FFFC, 4'b0101, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("bgtz_not_taken", pc, 32'h3014);
      applyStimulus(32'h0800_0C10, 4'b0000, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("j_target", pc, 32'h3040);
      applyStimulus(32'h0080_0008, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h3100, 32'd0);
      checkOutput("jr_3100", pc, 32'h3100);
      applyStimulus(32'h1485_0004, 4'b0011, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2);
      checkOutput("bne_taken", pc, 32'h3114);
      applyStimulus(32'h1485_0004, 4'b1101, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2);
      checkOutput("code110_not_taken", pc, 32'h3118);
      applyStimulus(32'h1085_0004, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd7, 32'd7);
      checkOutput("no_branch_bit", pc, 32'h311C);
      applyStimulus(32'h0080_0008, 4'b0000, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd0);
      checkOutput("jr_top", pc, 32'hFFFF_FFFC);
      applyStimulus(32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("pc_wrap", pc, 32'h0000_0000);
      applyStimulus(32'h0080_0008, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h3100, 32'd0);
      checkOutput("jr_3100b", pc, 32'h3100);
      applyStimulus(32'h0080_0008, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h3102, 32'd0);
      checkOutput("jr_bad_halted", {31'd0, halted}, 32'd1);
      checkOutput("jr_bad_fault", {31'd0, fault}, 32'd1);
      checkOutput("jr_bad_pc", pc, 32'h3100);
      checkOutput("jr_bad_req", {31'd0, imem_req}, 32'd0);

      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst2_pc", pc, 32'h3000);
      checkOutput("rst2_fault", {31'd0, fault}, 32'd0);
      checkOutput("rst2_halted", {31'd0, halted}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] halt");
      applyStimulus(32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("pre_halt_pc", pc, 32'h3004);
      applyStimulus(32'h0000_000C, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      imem_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
         tick();
      end
      imem_ready = 1'b0;
      checkOutput("halt_halted", {31'd0, halted}, 32'd1);
      checkOutput("halt_fault", {31'd0, fault}, 32'd0);
      checkOutput("halt_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("halt_pc", pc, 32'h3004);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("halt_rst_pc", pc, 32'h3000);
      checkOutput("halt_rst_halted", {31'd0, halted}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] reset mid-wait");
      applyStimulus(32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      tick();
      tick();
      checkOutput("mw_addr", imem_addr, 32'h3004);
      checkOutput("mw_req", {31'd0, imem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mw_rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("mw_rst_pc", pc, 32'h3000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checkOutput("mw_rel_req", {31'd0, imem_req}, 32'd1);
      checkOutput("mw_rel_addr", imem_addr, 32'h3000);
      applyStimulus(32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("mw_next_pc", pc, 32'h3004);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch and next-PC stage of the CPU. It sits directly upstream of `control_unit`. It owns the PC register and fetches each instruction from instruction memory over a req/ready handshake. It presents the instruction for one execute cycle, then resolves the next PC from the decoded `Branch`, `Jump`, `Jreg` and `PCWr` controls and the register-file operands. It also stops the core on `halt` or on a misaligned jump-register target.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded at reset.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: byte address of the requested instruction. Equal to `pc`.
- `imem_ready` in 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: latched instruction, fed to the decoder.
- `instr_valid` out 1: high during the execute cycle.
- `pc` out 32: address of the current instruction.
- `pc_4` out 32: `pc + 4`, used as the link value for jal/jalr.
- `exec_stall` in 1: datapath holds the execute cycle, e.g. while a data-memory access is pending.
- `branch` in 4: `control_unit` Branch encoding. Bit0 = branch instruction. Bits[3:1] select the condition: 000 beq, 001 bne, 010 bgtz, 011 bgez, 100 bltz, 101 blez.
- `jump` in 1, `jreg` in 1, `pc_wr` in 1: decoded controls from `control_unit`.
- `bus_a` in 32, `bus_b` in 32: GPR[rs] and GPR[rt].
- `halted` out 1: core stopped.
- `fault` out 1: stop was caused by a misaligned jr/jalr target.

## Operation
- States: FETCH, EXEC, HALT.
- **Reset:**
  - state = FETCH, `pc` = `RESET_PC`, `instr` = 0.
  - `instr_valid` = 0, `halted` = 0, `fault` = 0.
  - `imem_req` = 1 as soon as reset is released; it is 0 while `rst_n` is low.
- **FETCH:**
  - `imem_req` = 1; `imem_addr` = `pc` and stays stable until the handshake completes.
  - On `imem_ready`: latch `imem_rdata` into `instr` and go to EXEC.
  - `imem_ready` while `imem_req` = 0 is ignored.
- **EXEC:**
  - `instr_valid` = 1 and `imem_req` = 0. The decoder and datapath act on `instr` and `pc` combinationally.
  - If `exec_stall` = 1: stay in EXEC; `pc` and `instr` are held.
  - Otherwise, at the edge, evaluate in this priority order:
    1. `pc_wr` = 0: go to HALT; `pc` unchanged (points at the halt instruction).
    2. `jump` & `jreg`: if `bus_a[1:0]` != 0, go to HALT with `fault` = 1 and `pc` unchanged. Otherwise `pc` = `bus_a`.
    3. `jump`: `pc` = {`pc_4[31:28]`, `instr[25:0]`, 2'b00}.
    4. `branch[0]` and the condition is true: `pc` = `pc_4` + (sign-extended `instr[15:0]` << 2), with 32-bit wrap-around.
    5. Otherwise `pc` = `pc_4`.
  - Non-halt outcomes return to FETCH.
- **Branch conditions** (signed compares on `bus_a`):
  - beq: `bus_a` == `bus_b`; bne: `bus_a` != `bus_b`.
  - bgtz: `bus_a` > 0; bgez: `bus_a` >= 0.
  - bltz: `bus_a` < 0; blez: `bus_a` <= 0.
  - Codes 110 and 111 are not taken.
- **HALT:** absorbing. `halted` = 1, no requests, `instr_valid` = 0. Only reset exits.
- Arithmetic is 32-bit modulo. `pc` = 32'hFFFF_FFFC sequences to 0.

## Timing
- The fetch latency equals the number of memory wait cycles plus one FETCH cycle. A zero-wait memory (`imem_ready` in the same cycle as `imem_req`) gives 2 cycles per instruction.
- `pc`, `pc_4`, `instr` and `instr_valid` are registered or derived from registers. `imem_addr` updates the cycle after EXEC.
- Next-PC selection is combinational from the EXEC-cycle inputs. The decoder feeding it must settle within the same cycle.
- Reset asserted mid-fetch or mid-EXEC: immediate return to reset values. No partial PC update.

## Structure
- Package `cpu_pkg` holds:
  - the state enum (FETCH, EXEC, HALT);
  - the branch-code localparams (BR_BEQ … BR_BLEZ);
  - `RESET_PC_DEFAULT`.
- Sub-module `branch_cond`: combinational; inputs `branch[3:1]`, `bus_a`, `bus_b`; output `taken`.
- The top level holds the FSM, the PC register and the next-PC mux.

## Test plan
- **Reset + zero-wait fetch:**
  - Release reset; `imem_req` = 1, `imem_addr` = 0x3000.
  - With `ready` = 1 every cycle: `instr_valid` pulses every 2nd cycle; `pc` sequence 0x3000, 0x3004, 0x3008.
- **Wait states:** `imem_ready` delayed 3 cycles → `imem_addr` stable for 4 cycles, then the instruction executes once; `exec_stall` for 2 cycles holds `pc`.
- **Branches at `pc` = 0x3010 with imm = 0xFFFC:**
  - beq with `bus_a` = `bus_b` = 5 → next `pc` 0x3004.
  - bltz with `bus_a` = 0x8000_0000 → 0x3004.
  - bgtz with `bus_a` = 0 → 0x3014.
- **Jumps:**
  - j with `instr[25:0]` = 0x0000C10 → `pc` 0x0000_3040.
  - jr with `bus_a` = 0x3100 → `pc` 0x3100.
  - jr with `bus_a` = 0x3102 → `halted` = 1, `fault` = 1, `pc` stays at the jr address.
- **Halt:** `pc_wr` = 0 in EXEC → `halted` = 1, `imem_req` stays 0 for 20 cycles; assert `rst_n` low → `pc` = 0x3000, `halted` = 0.
- **Reset mid-wait:** drop `rst_n` during FETCH with `ready` low → `imem_req` = 0 immediately; on release, restart fetch at 0x3000.
